mc_controller: RTL and testbench
================================

MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have parameter ALUCTL_W, default 2; ALUControl width, legal values 2 or 3.
REQ-002 SHALL have ports: clk in 1, rising-edge clock; reset in 1, asynchronous active-high.
REQ-003 SHALL have ports: Cond in 4, Op in 2, Funct in 6, Rd in 4, all from the instruction register.
REQ-004 SHALL have ports: ALUFlags in 4 (NZCV from ALU); mem_ready in 1, memory completes access this cycle.
REQ-005 SHALL have outputs: PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA, each 1.
REQ-006 SHALL have outputs: ResultSrc 2, ALUSrcB 2, ImmSrc 2, RegSrc 2, ALUControl ALUCTL_W.
REQ-007 SHALL have outputs: state_o 4, current FSM state; illegal 1, one-cycle pulse on undefined Op.

Function
REQ-008 SHALL implement a Moore FSM: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BRANCH=9; codes 10-15 SHALL go to FETCH.
REQ-009 FETCH: AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, ALU add. Hold state while mem_ready=0. IRWrite=PCWrite=1 only in the cycle mem_ready=1, then go to DECODE.
REQ-010 DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, RegSrc/ImmSrc per Op (00:00/00, 01:10/01, 10:01/10).
REQ-011 DECODE: if CondEx=0, go to FETCH with no side effects.
REQ-012 DECODE with CondEx=1: Op=01 goes to MEMADR. Op=00 goes to EXECUTER if Funct[5]=0, else EXECUTEI. Op=10 goes to BRANCH. Op=11 pulses illegal and goes to FETCH.
REQ-013 CondEx SHALL decode Cond against the stored flags: EQ, NE, CS, CC, MI, PL, VS, VC, HI, LS, GE, LT, GT, LE, AL=1110; 1111 SHALL give 0.
REQ-014 MEMADR: ALUSrcA=0, ALUSrcB=01, add; go to MEMREAD if Funct[0]=1, else MEMWRITE.
REQ-015 MEMREAD: AdrSrc=1; hold until mem_ready=1, then go to MEMWB.
REQ-016 MEMWB: ResultSrc=01, RegW=1; PCWrite=1 if Rd=1111; go to FETCH.
REQ-017 MEMWRITE: AdrSrc=1, MemW=1 held for every wait cycle; go to FETCH on mem_ready=1.
REQ-018 EXECUTER (ALUSrcB=00) and EXECUTEI (ALUSrcB=01): ALUSrcA=0, ALU op from Funct[4:1]; go to ALUWB.
REQ-019 ALUWB: ResultSrc=00, RegW=1, PCWrite=1 if Rd=1111; go to FETCH.
REQ-020 Funct[4:1] mapping: 0100 ADD gives 0; 0010 SUB gives 1; 0000 AND gives 2; 1100 ORR gives 3.
REQ-021 When ALUCTL_W=3: 0001 EOR gives 4 and 1101 MOV gives 5. All unlisted codes SHALL give ADD.
REQ-022 BRANCH: ALUSrcA=0, ALUSrcB=01, ResultSrc=10, PCWrite=1; go to FETCH.
REQ-023 Flags register (4 bits) SHALL update in ALUWB only when Funct[5:4]... specifically when S=Funct[0]=1. NZ update always on S. CV update only for ADD/SUB/CMP.
REQ-024 All unlisted outputs SHALL be 0 in each state. Outputs SHALL depend only on state, registered flags and instruction inputs.
REQ-025 Latency without waits: branch 3 cycles, data-processing 4, STR 4, LDR 5.

Reset
REQ-026 reset=1 SHALL force state FETCH and flags 0000 immediately, independent of clk.
REQ-027 Mid-access reset SHALL drop MemW, RegW and PCWrite in the same cycle.
REQ-028 After reset release, the first clk edge SHALL evaluate FETCH normally.

Configuration
REQ-029 Macro MC_CMP_EN defined: Funct[4:1]=1010 with S=1 SHALL perform SUB, update NZCV in ALUWB, and keep RegW=0 and PCWrite=0.
REQ-030 Macro MC_CMP_EN undefined: 1010 SHALL decode as ADD with normal write-back.

Verification
REQ-031 Reset mid-MEMWRITE with mem_ready=0: MemW falls to 0 asynchronously; state_o=0; flags=0000.
REQ-032 ADD R1 (Op=00, Funct=001000, Cond=1110), mem_ready=1: state sequence 0,1,6,8,0; RegW=1 only in state 8; ALUControl=0.
REQ-033 LDR with mem_ready low 3 cycles in MEMREAD: state 3 held 3 cycles; MEMWB RegW=1; Rd=1111 also gives PCWrite=1.
REQ-034 SUBS result zero (ALUFlags=0110), then BEQ: Cond=0000 gives states 0,1,9 with PCWrite=1; Cond=0001 gives 0,1,0.
REQ-035 Op=11: illegal=1 for exactly one cycle in DECODE; next state 0; no write strobes.
REQ-036 MC_CMP_EN defined, CMP with Funct=010101: flags update, RegW=0 in ALUWB; with the macro undefined, RegW=1 and ALUControl=0.

Source files
------------

// File: rtl/mc_controller_if.sv
// Instruction, flag, memory-handshake and control-strobe bundle for mc_controller.
interface mc_controller_if #(
  parameter int ALUCTL_W = 2
);
  logic [3:0]          Cond;
  logic [1:0]          Op;
  logic [5:0]          Funct;
  logic [3:0]          Rd;
  logic [3:0]          ALUFlags;
  logic                mem_ready;

  logic                PCWrite;
  logic                AdrSrc;
  logic                MemW;
  logic                IRWrite;
  logic                RegW;
  logic                ALUSrcA;
  logic [1:0]          ResultSrc;
  logic [1:0]          ALUSrcB;
  logic [1:0]          ImmSrc;
  logic [1:0]          RegSrc;
  logic [ALUCTL_W-1:0] ALUControl;
  logic [3:0]          state_o;
  logic                illegal;

  modport master (
    output Cond, Op, Funct, Rd, ALUFlags, mem_ready,
    input  PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA, ResultSrc, ALUSrcB,
           ImmSrc, RegSrc, ALUControl, state_o, illegal
  );

  modport slave (
    input  Cond, Op, Funct, Rd, ALUFlags, mem_ready,
    output PCWrite, AdrSrc, MemW, IRWrite, RegW, ALUSrcA, ResultSrc, ALUSrcB,
           ImmSrc, RegSrc, ALUControl, state_o, illegal
  );
endinterface

// File: rtl/mc_controller.sv
// Multicycle ARM-subset Moore controller with condition flags register.
// Define MC_CMP_EN to decode Funct[4:1]=1010 with S=1 as a flag-only compare.
module mc_controller #(
  parameter int ALUCTL_W = 2
) (
  input  logic            clk,
  input  logic            reset,
  mc_controller_if.slave  bus
);

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTER = 4'd6,
    EXECUTEI = 4'd7,
    ALUWB    = 4'd8,
    BRANCH   = 4'd9
  } state_t;

  state_t     state, next;
  logic [3:0] flags;
  logic       condex;
  logic [3:0] cmd;
  logic       sbit;
  logic       is_cmp;
  logic       arith;
  logic [2:0] alu_op;
  logic [2:0] aluc;

  assign cmd  = bus.Funct[4:1];
  assign sbit = bus.Funct[0];

`ifdef MC_CMP_EN
  assign is_cmp = (cmd == 4'b1010) && sbit;
`else
  assign is_cmp = 1'b0;
`endif

  // Carry/overflow are only meaningful after an adder operation.
  assign arith = (cmd == 4'b0100) || (cmd == 4'b0010) || is_cmp;

  always_comb begin
    alu_op = 3'd0;
    case (cmd)
      4'b0100: alu_op = 3'd0;
      4'b0010: alu_op = 3'd1;
      4'b0000: alu_op = 3'd2;
      4'b1100: alu_op = 3'd3;
      4'b0001: alu_op = (ALUCTL_W == 3) ? 3'd4 : 3'd0;
      4'b1101: alu_op = (ALUCTL_W == 3) ? 3'd5 : 3'd0;
      default: alu_op = 3'd0;
    endcase
    if (is_cmp) alu_op = 3'd1;
  end

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = flags;
    condex = 1'b0;
    case (bus.Cond)
      4'b0000: condex = z;
      4'b0001: condex = ~z;
      4'b0010: condex = c;
      4'b0011: condex = ~c;
      4'b0100: condex = n;
      4'b0101: condex = ~n;
      4'b0110: condex = v;
      4'b0111: condex = ~v;
      4'b1000: condex = c & ~z;
      4'b1001: condex = ~c | z;
      4'b1010: condex = (n == v);
      4'b1011: condex = (n != v);
      4'b1100: condex = ~z & (n == v);
      4'b1101: condex = z | (n != v);
      4'b1110: condex = 1'b1;
      default: condex = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= FETCH;
    else       state <= next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flags <= '0;
    end else if (state == ALUWB && sbit) begin
      flags[3:2] <= bus.ALUFlags[3:2];
      if (arith) flags[1:0] <= bus.ALUFlags[1:0];
    end
  end

  always_comb begin
    next          = FETCH;
    aluc          = 3'd0;
    bus.PCWrite   = 1'b0;
    bus.AdrSrc    = 1'b0;
    bus.MemW      = 1'b0;
    bus.IRWrite   = 1'b0;
    bus.RegW      = 1'b0;
    bus.ALUSrcA   = 1'b0;
    bus.ResultSrc = 2'b00;
    bus.ALUSrcB   = 2'b00;
    bus.ImmSrc    = 2'b00;
    bus.RegSrc    = 2'b00;
    bus.illegal   = 1'b0;
    case (state)
      FETCH: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        if (bus.mem_ready) begin
          bus.IRWrite = 1'b1;
          bus.PCWrite = 1'b1;
          next        = DECODE;
        end else begin
          next = FETCH;
        end
      end
      DECODE: begin
        bus.ALUSrcA   = 1'b1;
        bus.ALUSrcB   = 2'b10;
        bus.ResultSrc = 2'b10;
        case (bus.Op)
          2'b01: begin bus.RegSrc = 2'b10; bus.ImmSrc = 2'b01; end
          2'b10: begin bus.RegSrc = 2'b01; bus.ImmSrc = 2'b10; end
          default: ;
        endcase
        if (condex) begin
          case (bus.Op)
            2'b00:   next = bus.Funct[5] ? EXECUTEI : EXECUTER;
            2'b01:   next = MEMADR;
            2'b10:   next = BRANCH;
            default: bus.illegal = 1'b1;
          endcase
        end
      end
      MEMADR: begin
        bus.ALUSrcB = 2'b01;
        next        = bus.Funct[0] ? MEMREAD : MEMWRITE;
      end
      MEMREAD: begin
        bus.AdrSrc = 1'b1;
        next       = bus.mem_ready ? MEMWB : MEMREAD;
      end
      MEMWB: begin
        bus.ResultSrc = 2'b01;
        bus.RegW      = 1'b1;
        bus.PCWrite   = (bus.Rd == 4'hF);
      end
      MEMWRITE: begin
        bus.AdrSrc = 1'b1;
        bus.MemW   = 1'b1;
        next       = bus.mem_ready ? FETCH : MEMWRITE;
      end
      EXECUTER: begin
        aluc = alu_op;
        next = ALUWB;
      end
      EXECUTEI: begin
        bus.ALUSrcB = 2'b01;
        aluc        = alu_op;
        next        = ALUWB;
      end
      ALUWB: begin
        bus.RegW    = ~is_cmp;
        bus.PCWrite = (bus.Rd == 4'hF) && !is_cmp;
      end
      BRANCH: begin
        bus.ALUSrcB   = 2'b01;
        bus.ResultSrc = 2'b10;
        bus.PCWrite   = 1'b1;
      end
      default: next = FETCH;
    endcase
  end

  assign bus.ALUControl = ALUCTL_W'(aluc);
  assign bus.state_o    = state;

endmodule

// File: tb/tb_mc_controller.sv
// Scoreboard bench for mc_controller: per-instruction cycle traces built from the ISA rules.
module tb_mc_controller;
  localparam int AW = 3;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adrsrc, memw, irw, regw, srca;
    logic [1:0] res, srcb, imm, regsrc;
    logic [2:0] aluc;
    logic       ill;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   checks = 0;
  int   errors = 0;
  exp_t exp_q[$];
  logic [3:0] mflags = 4'b0000;

  mc_controller_if #(.ALUCTL_W(AW)) bus_if ();
  mc_controller #(.ALUCTL_W(AW)) dut (.clk(clk), .reset(reset), .bus(bus_if));

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, expv);
    end
  endtask

  // Monitor: every cycle with a pending expectation is compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e, a;
      e = exp_q.pop_front();
      a = '{st: bus_if.state_o, pcw: bus_if.PCWrite, adrsrc: bus_if.AdrSrc,
            memw: bus_if.MemW, irw: bus_if.IRWrite, regw: bus_if.RegW,
            srca: bus_if.ALUSrcA, res: bus_if.ResultSrc, srcb: bus_if.ALUSrcB,
            imm: bus_if.ImmSrc, regsrc: bus_if.RegSrc,
            aluc: 3'(bus_if.ALUControl), ill: bus_if.illegal};
      checks++;
      if (a !== e) begin
        errors++;
        $display("FAIL cycle_state%0d: got %h expected %h at %0t", e.st, a, e, $time);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cy, v;
    {n, z, cy, v} = f;
    case (c)
      4'd0:  return z;
      4'd1:  return !z;
      4'd2:  return cy;
      4'd3:  return !cy;
      4'd4:  return n;
      4'd5:  return !n;
      4'd6:  return v;
      4'd7:  return !v;
      4'd8:  return cy && !z;
      4'd9:  return !cy || z;
      4'd10: return n == v;
      4'd11: return n != v;
      4'd12: return !z && n == v;
      4'd13: return z || n != v;
      4'd14: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic model_cmp(input logic [5:0] f);
`ifdef MC_CMP_EN
    return f[4:1] == 4'b1010 && f[0];
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [2:0] model_alu(input logic [5:0] f);
    if (model_cmp(f)) return 3'd1;
    case (f[4:1])
      4'b0100: return 3'd0;
      4'b0010: return 3'd1;
      4'b0000: return 3'd2;
      4'b1100: return 3'd3;
      4'b0001: return (AW == 3) ? 3'd4 : 3'd0;
      4'b1101: return (AW == 3) ? 3'd5 : 3'd0;
      default: return 3'd0;
    endcase
  endfunction

  function automatic exp_t blank(input logic [3:0] st);
    exp_t e;
    e = '0;
    e.st = st;
    return e;
  endfunction

  task automatic cyc(input exp_t e, input logic mr);
    bus_if.mem_ready = mr;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  // One instruction: fetch with fw wait cycles, memory stage with mw wait cycles.
  task automatic run_instr(input logic [3:0] c, input logic [1:0] o, input logic [5:0] f,
                           input logic [3:0] rd, input logic [3:0] af,
                           input int unsigned fw, input int unsigned mw);
    exp_t e;
    logic ce, cmp;
    bus_if.Cond = c; bus_if.Op = o; bus_if.Funct = f; bus_if.Rd = rd; bus_if.ALUFlags = af;
    ce  = cond_holds(c, mflags);
    cmp = model_cmp(f);
    for (int unsigned i = 0; i < fw; i++) begin
      e = blank(4'd0); e.srca = 1; e.srcb = 2'b10; e.res = 2'b10;
      cyc(e, 1'b0);
    end
    e = blank(4'd0); e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; e.irw = 1; e.pcw = 1;
    cyc(e, 1'b1);
    e = blank(4'd1); e.srca = 1; e.srcb = 2'b10; e.res = 2'b10;
    if (o == 2'd1) begin e.regsrc = 2'b10; e.imm = 2'b01; end
    if (o == 2'd2) begin e.regsrc = 2'b01; e.imm = 2'b10; end
    e.ill = ce && o == 2'd3;
    cyc(e, 1'($urandom));
    if (!ce || o == 2'd3) return;
    if (o == 2'd1) begin
      e = blank(4'd2); e.srcb = 2'b01;
      cyc(e, 1'($urandom));
      if (f[0]) begin
        for (int unsigned i = 0; i <= mw; i++) begin
          e = blank(4'd3); e.adrsrc = 1;
          cyc(e, i == mw);
        end
        e = blank(4'd4); e.res = 2'b01; e.regw = 1; e.pcw = (rd == 4'hF);
        cyc(e, 1'($urandom));
      end else begin
        for (int unsigned i = 0; i <= mw; i++) begin
          e = blank(4'd5); e.adrsrc = 1; e.memw = 1;
          cyc(e, i == mw);
        end
      end
    end else if (o == 2'd0) begin
      e = blank(f[5] ? 4'd7 : 4'd6); e.srcb = f[5] ? 2'b01 : 2'b00; e.aluc = model_alu(f);
      cyc(e, 1'($urandom));
      e = blank(4'd8); e.regw = !cmp; e.pcw = (rd == 4'hF) && !cmp;
      cyc(e, 1'($urandom));
      if (f[0]) begin
        mflags[3:2] = af[3:2];
        if (f[4:1] == 4'b0100 || f[4:1] == 4'b0010 || cmp) mflags[1:0] = af[1:0];
      end
    end else begin
      e = blank(4'd9); e.srcb = 2'b01; e.res = 2'b10; e.pcw = 1;
      cyc(e, 1'($urandom));
    end
  endtask

  initial begin
    bus_if.Cond = 4'hE; bus_if.Op = 2'd0; bus_if.Funct = '0; bus_if.Rd = '0;
    bus_if.ALUFlags = '0; bus_if.mem_ready = 1'b1;
    #3;
    chk("reset_state", 32'(bus_if.state_o), 32'd0);
    chk("reset_memw", 32'(bus_if.MemW), 32'd0);
    chk("reset_regw", 32'(bus_if.RegW), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(4'hE, 2'd0, 6'b001000, 4'd1, 4'h0, 0, 0);        // ADD R1
    run_instr(4'hE, 2'd1, 6'b011001, 4'hF, 4'h0, 1, 3);        // LDR PC, 3 waits
    run_instr(4'hE, 2'd0, 6'b000101, 4'd2, 4'b0110, 0, 0);     // SUBS, result zero
    run_instr(4'h0, 2'd2, 6'b000000, 4'd0, 4'h0, 0, 0);        // BEQ taken
    run_instr(4'h1, 2'd2, 6'b000000, 4'd0, 4'h0, 0, 0);        // BNE not taken
    run_instr(4'hE, 2'd3, 6'b000000, 4'd0, 4'h0, 0, 0);        // undefined Op
    run_instr(4'hE, 2'd0, 6'b010101, 4'd3, 4'b1001, 0, 0);     // CMP
    run_instr(4'hB, 2'd2, 6'b000000, 4'd0, 4'h0, 0, 0);        // BLT follows CMP flags
    run_instr(4'hF, 2'd0, 6'b001000, 4'd1, 4'h0, 0, 0);        // never
    run_instr(4'hE, 2'd0, 6'b100011, 4'hF, 4'b1111, 2, 0);     // EOR imm, S, Rd=PC
    run_instr(4'hE, 2'd1, 6'b011000, 4'd4, 4'h0, 0, 2);        // STR with waits

    // Reset in the middle of a stalled store.
    bus_if.Cond = 4'hE; bus_if.Op = 2'd1; bus_if.Funct = 6'b011000; bus_if.Rd = 4'd5;
    begin
      exp_t e;
      e = blank(4'd0); e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; e.irw = 1; e.pcw = 1;
      cyc(e, 1'b1);
      e = blank(4'd1); e.srca = 1; e.srcb = 2'b10; e.res = 2'b10; e.regsrc = 2'b10; e.imm = 2'b01;
      cyc(e, 1'b0);
      e = blank(4'd2); e.srcb = 2'b01;
      cyc(e, 1'b0);
      e = blank(4'd5); e.adrsrc = 1; e.memw = 1;
      cyc(e, 1'b0);
    end
    chk("memwrite_stall_memw", 32'(bus_if.MemW), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_memw", 32'(bus_if.MemW), 32'd0);
    chk("async_reset_state", 32'(bus_if.state_o), 32'd0);
    chk("async_reset_pcw", 32'(bus_if.PCWrite), 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    mflags = 4'b0000;
    run_instr(4'h0, 2'd2, 6'b000000, 4'd0, 4'h0, 0, 0);        // BEQ after flag clear
    run_instr(4'h3, 2'd2, 6'b000000, 4'd0, 4'h0, 0, 0);        // BCC after flag clear

    for (int n = 0; n < 300; n++) begin
      int unsigned r;
      logic [1:0] o;
      logic [3:0] c, rd;
      r  = $urandom_range(0, 9);
      o  = (r < 4) ? 2'd0 : (r < 7) ? 2'd1 : (r < 9) ? 2'd2 : 2'd3;
      c  = ($urandom_range(0, 9) < 5) ? 4'hE : 4'($urandom);
      rd = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      run_instr(c, o, 6'($urandom), rd, 4'($urandom),
                $urandom_range(0, 2), $urandom_range(0, 3));
    end

    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
